// File: rtl/dtack_wait_state_generator.sv
// dtack_wait_state_generator: 68k DTACK/BERR generator for NUM_CH selects.
// Internal channels count wait states; external ones pass a controller ack.
//
// Ports:
//   Clock           system clock, all state on rising edge
//   Reset_L         asynchronous active-low reset
//   AS_L            68k address strobe, synchronous to Clock
//   Select_H        decoder selects, active high, lowest index wins
//   ExtDtack_L      per-channel controller ack (external channels only)
//   WaitStates      packed per-channel wait counts, WAIT_W bits each
//   TimeoutClr_H    clears the sticky timeout status
//   DtackOut_L      registered DTACK to the CPU
//   BErrOut_L       registered BERR to the CPU
//   TimeoutStatus_H sticky timeout flag
//   TimeoutChan     channel of the most recent timeout
module dtack_wait_state_generator #(
   parameter int                NUM_CH         = 4,
   parameter int                WAIT_W         = 4,
   parameter logic [NUM_CH-1:0] EXT_MASK       = NUM_CH'(4'b0011),
   parameter int                TIMEOUT_CYCLES = 256,
   parameter int                CH_W           = (NUM_CH > 1) ?
                                                 $clog2(NUM_CH) : 1
) (
   input  logic                     Clock,
   input  logic                     Reset_L,
   input  logic                     AS_L,
   input  logic [NUM_CH-1:0]        Select_H,
   input  logic [NUM_CH-1:0]        ExtDtack_L,
   input  logic [NUM_CH*WAIT_W-1:0] WaitStates,
   input  logic                     TimeoutClr_H,
   output logic                     DtackOut_L,
   output logic                     BErrOut_L,
   output logic                     TimeoutStatus_H,
   output logic [CH_W-1:0]          TimeoutChan
);

   // tcnt must hold 0..TIMEOUT_CYCLES; keep at least one bit when disabled
   localparam int TCNT_W = (TIMEOUT_CYCLES > 0) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int TLAST_I = (TIMEOUT_CYCLES > 0) ?
                            TIMEOUT_CYCLES - 1 : 0;
   localparam logic [TCNT_W-1:0] TLAST = TCNT_W'(TLAST_I);
   localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WAIT = 3'd1,
      EXT  = 3'd2,
      ACK  = 3'd3,
      BERR = 3'd4
   } state_t;

   state_t            state;
   state_t            stateNext;
   logic [CH_W-1:0]   sel;
   logic [CH_W-1:0]   selNext;
   logic [WAIT_W-1:0] wcnt;
   logic [WAIT_W-1:0] wcntNext;
   logic [TCNT_W-1:0] tcnt;
   logic [TCNT_W-1:0] tcntNext;
   logic              statusNext;
   logic [CH_W-1:0]   chanNext;
   logic              dtackNext;
   logic              berrNext;
   logic              timeoutSet;

   logic              hit;
   logic [CH_W-1:0]   pick;
   logic [WAIT_W-1:0] pickWait;
   logic              pickExt;
   logic              selAck;
   logic              tLast;

   // Priority encoder: scanning downward leaves the lowest set index
   always_comb begin
      hit  = 1'b0;
      pick = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (Select_H[i]) begin
            hit  = 1'b1;
            pick = CH_W'(i);
         end
      end
   end

   assign pickWait = WaitStates[int'(pick)*WAIT_W +: WAIT_W];
   assign pickExt  = EXT_MASK[pick];
   assign selAck   = ~ExtDtack_L[sel];
   assign tLast    = TO_EN && (tcnt == TLAST);

   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         state           <= IDLE;
         sel             <= '0;
         wcnt            <= '0;
         tcnt            <= '0;
         DtackOut_L      <= 1'b1;
         BErrOut_L       <= 1'b1;
         TimeoutStatus_H <= 1'b0;
         TimeoutChan     <= '0;
      end else begin
         state           <= stateNext;
         sel             <= selNext;
         wcnt            <= wcntNext;
         tcnt            <= tcntNext;
         DtackOut_L      <= dtackNext;
         BErrOut_L       <= berrNext;
         TimeoutStatus_H <= statusNext;
         TimeoutChan     <= chanNext;
      end
   end

   always_comb begin
      stateNext  = state;
      selNext    = sel;
      wcntNext   = wcnt;
      tcntNext   = tcnt;
      timeoutSet = 1'b0;

      unique case (state)
         IDLE: begin
            if (!AS_L) begin
               tcntNext = '0;
               selNext  = pick;
               if (!hit) begin
                  stateNext = ACK;
               end else if (pickExt) begin
                  stateNext = EXT;
               end else if (pickWait == '0) begin
                  stateNext = ACK;
               end else begin
                  wcntNext  = pickWait;
                  stateNext = WAIT;
               end
            end
         end

         WAIT: begin
            if (AS_L) begin
               stateNext = IDLE;
            end else if (wcnt == WAIT_W'(1)) begin
               stateNext = ACK;
            end else begin
               wcntNext = wcnt - WAIT_W'(1);
               if (TO_EN) tcntNext = tcnt + TCNT_W'(1);
               if (tLast) begin
                  stateNext  = BERR;
                  timeoutSet = 1'b1;
               end
            end
         end

         EXT: begin
            if (AS_L) begin
               stateNext = IDLE;
            end else if (selAck) begin
               stateNext = ACK;
            end else begin
               if (TO_EN) tcntNext = tcnt + TCNT_W'(1);
               if (tLast) begin
                  stateNext  = BERR;
                  timeoutSet = 1'b1;
               end
            end
         end

         ACK, BERR: begin
            if (AS_L) stateNext = IDLE;
         end

         default: stateNext = IDLE;
      endcase
   end

   // A timeout on the same edge as a clear keeps the flag set
   assign statusNext = timeoutSet |
                       (TimeoutStatus_H & ~TimeoutClr_H);
   assign chanNext   = timeoutSet ? sel : TimeoutChan;
   assign dtackNext  = (stateNext != ACK);
   assign berrNext   = (stateNext != BERR);

endmodule

// File: tb/tb_dtack_wait_state_generator.sv
// tb_dtack_wait_state_generator: directed checks of DTACK, wait states,
// external ack, timeout/BERR, abort and mid-cycle reset.
module tb_dtack_wait_state_generator;

   logic        Clock = 1'b0;
   logic        Reset_L;
   logic        AS_L;
   logic [3:0]  Select_H;
   logic [3:0]  ExtDtack_L;
   logic [15:0] WaitStates;
   logic        TimeoutClr_H;
   logic        DtackOut_L;
   logic        BErrOut_L;
   logic        TimeoutStatus_H;
   logic [1:0]  TimeoutChan;

   int checks = 0;
   int errors = 0;

   dtack_wait_state_generator #(
      .NUM_CH(4),
      .WAIT_W(4),
      .EXT_MASK(4'b0011),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .Clock(Clock),
      .Reset_L(Reset_L),
      .AS_L(AS_L),
      .Select_H(Select_H),
      .ExtDtack_L(ExtDtack_L),
      .WaitStates(WaitStates),
      .TimeoutClr_H(TimeoutClr_H),
      .DtackOut_L(DtackOut_L),
      .BErrOut_L(BErrOut_L),
      .TimeoutStatus_H(TimeoutStatus_H),
      .TimeoutChan(TimeoutChan)
   );

   always #5 Clock = ~Clock;

   // One rising edge, then park on the falling edge to drive and sample
   task automatic tick();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   task automatic test_reset();
      Reset_L = 1'b1;
      AS_L = 1'b1;
      Select_H = 4'b0000;
      ExtDtack_L = 4'b1111;
      WaitStates = 16'h0000;
      TimeoutClr_H = 1'b0;
      #2 Reset_L = 1'b0;
      #1;
      checks++;
      if ({DtackOut_L, BErrOut_L, TimeoutStatus_H, TimeoutChan} !== 5'b11000) begin
         errors++;
         $display("FAIL reset_outputs: got %b want %b",
                  {DtackOut_L, BErrOut_L, TimeoutStatus_H, TimeoutChan}, 5'b11000);
      end
      tick();
      tick();
      Reset_L = 1'b1;
      tick();
      checks++;
      if ({DtackOut_L, BErrOut_L} !== 2'b11) begin
         errors++;
         $display("FAIL reset_release: got %b want 11", {DtackOut_L, BErrOut_L});
      end
   endtask

   task automatic test_no_select();
      Select_H = 4'b0000;
      AS_L = 1'b0;
      tick();
      checks++;
      if (DtackOut_L !== 1'b0) begin
         errors++;
         $display("FAIL nosel_E0: dtack %b want 0", DtackOut_L);
      end
      tick();
      tick();
      checks++;
      if (DtackOut_L !== 1'b0) begin
         errors++;
         $display("FAIL nosel_hold_E2: dtack %b want 0", DtackOut_L);
      end
      AS_L = 1'b1;
      tick();
      checks++;
      if ({DtackOut_L, BErrOut_L} !== 2'b11) begin
         errors++;
         $display("FAIL nosel_E3_release: got %b want 11", {DtackOut_L, BErrOut_L});
      end
   endtask

   task automatic test_internal_wait();
      Select_H = 4'b0100;
      WaitStates = 16'h0500;
      AS_L = 1'b0;
      tick();
      for (int k = 0; k <= 4; k++) begin
         checks++;
         if (DtackOut_L !== 1'b1) begin
            errors++;
            $display("FAIL wait5_early_E%0d: dtack %b want 1", k, DtackOut_L);
         end
         if (k < 4) tick();
      end
      tick();
      checks++;
      if (DtackOut_L !== 1'b0) begin
         errors++;
         $display("FAIL wait5_E5: dtack %b want 0", DtackOut_L);
      end
      tick();
      checks++;
      if (DtackOut_L !== 1'b0) begin
         errors++;
         $display("FAIL wait5_hold_E6: dtack %b want 0", DtackOut_L);
      end
      AS_L = 1'b1;
      tick();
      checks++;
      if (DtackOut_L !== 1'b1) begin
         errors++;
         $display("FAIL wait5_release: dtack %b want 1", DtackOut_L);
      end
      WaitStates = 16'h0000;
      AS_L = 1'b0;
      tick();
      checks++;
      if (DtackOut_L !== 1'b0) begin
         errors++;
         $display("FAIL wait0_E0: dtack %b want 0", DtackOut_L);
      end
      AS_L = 1'b1;
      tick();
   endtask

   task automatic test_external();
      Select_H = 4'b0011;
      ExtDtack_L = 4'b1111;
      AS_L = 1'b0;
      tick();
      for (int k = 1; k <= 6; k++) tick();
      checks++;
      if (DtackOut_L !== 1'b1) begin
         errors++;
         $display("FAIL ext_before_ack_E6: dtack %b want 1", DtackOut_L);
      end
      ExtDtack_L = 4'b1110;
      tick();
      checks++;
      if ({DtackOut_L, BErrOut_L} !== 2'b01) begin
         errors++;
         $display("FAIL ext_ack_E7: got %b want 01", {DtackOut_L, BErrOut_L});
      end
      AS_L = 1'b1;
      ExtDtack_L = 4'b1111;
      tick();
      checks++;
      if (DtackOut_L !== 1'b1) begin
         errors++;
         $display("FAIL ext_release: dtack %b want 1", DtackOut_L);
      end
   endtask

   task automatic test_timeout();
      Select_H = 4'b0010;
      ExtDtack_L = 4'b1111;
      AS_L = 1'b0;
      tick();
      for (int k = 1; k <= 15; k++) tick();
      checks++;
      if (BErrOut_L !== 1'b1) begin
         errors++;
         $display("FAIL timeout_E15: berr %b want 1", BErrOut_L);
      end
      tick();
      checks++;
      if ({DtackOut_L, BErrOut_L, TimeoutStatus_H, TimeoutChan} !== 5'b10101) begin
         errors++;
         $display("FAIL timeout_E16: got %b want 10101",
                  {DtackOut_L, BErrOut_L, TimeoutStatus_H, TimeoutChan});
      end
      AS_L = 1'b1;
      tick();
      checks++;
      if ({BErrOut_L, TimeoutStatus_H} !== 2'b11) begin
         errors++;
         $display("FAIL timeout_release: got %b want 11", {BErrOut_L, TimeoutStatus_H});
      end
      TimeoutClr_H = 1'b1;
      tick();
      TimeoutClr_H = 1'b0;
      checks++;
      if (TimeoutStatus_H !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear: status %b want 0", TimeoutStatus_H);
      end
      AS_L = 1'b0;
      tick();
      for (int k = 1; k <= 15; k++) tick();
      ExtDtack_L = 4'b1101;
      tick();
      checks++;
      if ({DtackOut_L, BErrOut_L, TimeoutStatus_H} !== 3'b010) begin
         errors++;
         $display("FAIL ack_vs_timeout: got %b want 010",
                  {DtackOut_L, BErrOut_L, TimeoutStatus_H});
      end
      AS_L = 1'b1;
      ExtDtack_L = 4'b1111;
      tick();
      AS_L = 1'b0;
      tick();
      for (int k = 1; k <= 15; k++) tick();
      TimeoutClr_H = 1'b1;
      tick();
      checks++;
      if ({BErrOut_L, TimeoutStatus_H} !== 2'b01) begin
         errors++;
         $display("FAIL set_vs_clear: got %b want 01", {BErrOut_L, TimeoutStatus_H});
      end
      tick();
      TimeoutClr_H = 1'b0;
      checks++;
      if (TimeoutStatus_H !== 1'b0) begin
         errors++;
         $display("FAIL clear_after_set: status %b want 0", TimeoutStatus_H);
      end
      AS_L = 1'b1;
      tick();
   endtask

   task automatic test_abort();
      Select_H = 4'b1000;
      WaitStates = 16'hA000;
      AS_L = 1'b0;
      tick();
      for (int k = 1; k <= 3; k++) tick();
      AS_L = 1'b1;
      tick();
      for (int k = 5; k <= 12; k++) begin
         checks++;
         if ({DtackOut_L, BErrOut_L, TimeoutStatus_H} !== 3'b110) begin
            errors++;
            $display("FAIL abort_E%0d: got %b want 110", k - 1,
                     {DtackOut_L, BErrOut_L, TimeoutStatus_H});
         end
         tick();
      end
      AS_L = 1'b0;
      tick();
      for (int k = 1; k <= 9; k++) tick();
      checks++;
      if (DtackOut_L !== 1'b1) begin
         errors++;
         $display("FAIL after_abort_E9: dtack %b want 1", DtackOut_L);
      end
      tick();
      checks++;
      if (DtackOut_L !== 1'b0) begin
         errors++;
         $display("FAIL after_abort_E10: dtack %b want 0", DtackOut_L);
      end
      AS_L = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      Select_H = 4'b0000;
      AS_L = 1'b0;
      tick();
      AS_L = 1'b1;
      tick();
      AS_L = 1'b0;
      tick();
      checks++;
      if (DtackOut_L !== 1'b0) begin
         errors++;
         $display("FAIL b2b_second_E0: dtack %b want 0", DtackOut_L);
      end
      AS_L = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid();
      Select_H = 4'b0010;
      ExtDtack_L = 4'b1111;
      AS_L = 1'b0;
      tick();
      for (int k = 1; k <= 16; k++) tick();
      AS_L = 1'b1;
      tick();
      Select_H = 4'b1000;
      WaitStates = 16'hA000;
      AS_L = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if ({TimeoutStatus_H, TimeoutChan} !== 3'b101) begin
         errors++;
         $display("FAIL premid_status: got %b want 101", {TimeoutStatus_H, TimeoutChan});
      end
      Reset_L = 1'b0;
      AS_L = 1'b1;
      #1;
      checks++;
      if ({DtackOut_L, BErrOut_L, TimeoutStatus_H, TimeoutChan} !== 5'b11000) begin
         errors++;
         $display("FAIL midreset_async: got %b want 11000",
                  {DtackOut_L, BErrOut_L, TimeoutStatus_H, TimeoutChan});
      end
      @(negedge Clock);
      Reset_L = 1'b1;
      for (int k = 0; k < 12; k++) tick();
      checks++;
      if ({DtackOut_L, BErrOut_L} !== 2'b11) begin
         errors++;
         $display("FAIL midreset_dropped: got %b want 11", {DtackOut_L, BErrOut_L});
      end
   endtask

   initial begin
      test_reset();
      test_no_select();
      test_internal_wait();
      test_external();
      test_timeout();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
